// File: rtl/host_bus_master_pkg.sv
// Shared framing bytes and FSM state encodings for the host link bridge.
// Channel blocks and host-side software definitions take their constants from here.
package host_bus_master_pkg;

   localparam logic [7:0] SOF_RX = 8'hAA;
   localparam logic [7:0] SOF_TX = 8'h55;

   typedef enum logic [1:0] {
      RX_SOF,
      RX_ADDR,
      RX_LEN,
      RX_PAY
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_SCAN,
      TX_SOF,
      TX_ADDR,
      TX_LEN,
      TX_PAY
   } tx_state_t;

endpackage

// File: rtl/host_bus_master_rr_arbiter.sv
// Combinational round-robin arbiter: the first request strictly after `last`
// (wrapping) wins, reported both as a one-hot grant and as an index.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          hit
);

   always_comb begin
      int k;
      grant = '0;
      idx   = '0;
      hit   = 1'b0;
      k     = 0;
      for (int i = 1; i <= N; i++) begin
         k = int'(last) + i;
         if (k >= N) k = k - N;
         if (!hit && req[k]) begin
            grant[k] = 1'b1;
            idx      = IW'(k);
            hit      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/host_bus_master.sv
// Full-duplex bridge: host command packets -> per-channel payload strobes, and
// round-robin drained channel FIFOs -> framed reply packets toward the host.
module host_bus_master
   import host_bus_master_pkg::*;
#(
   parameter int          N_CH    = 5,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic              sys_clk,
   input  logic              n_rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        master_data,
   output logic [N_CH-1:0]   valid_bus,
   input  logic [N_CH-1:0]   have_msg_bus,
   input  logic [8*N_CH-1:0] len_bus,
   output logic [N_CH-1:0]   rdreq_bus,
   input  logic [8*N_CH-1:0] slave_data_bus
);

   localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

   rx_state_t   rx_state;
   logic [7:0]  addr;
   logic [7:0]  cnt;
   logic [15:0] gap;

   // The gap counter saturates; an abort fires on the idle cycle that brings it to TIMEOUT.
   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_state    <= RX_SOF;
         addr        <= '0;
         cnt         <= '0;
         gap         <= '0;
         master_data <= '0;
         valid_bus   <= '0;
      end else begin
         valid_bus <= '0;
         if (rx_valid) begin
            gap <= '0;
            case (rx_state)
               RX_SOF: begin
                  if (rx_data == SOF_RX) rx_state <= RX_ADDR;
               end
               RX_ADDR: begin
                  addr     <= rx_data;
                  rx_state <= RX_LEN;
               end
               RX_LEN: begin
                  cnt      <= rx_data;
                  rx_state <= (rx_data == 8'd0) ? RX_SOF : RX_PAY;
               end
               RX_PAY: begin
                  master_data <= rx_data;
                  valid_bus   <= (int'(addr) < N_CH) ? (N_CH'(1) << addr) : '0;
                  cnt         <= cnt - 8'd1;
                  if (cnt == 8'd1) rx_state <= RX_SOF;
               end
               default: rx_state <= RX_SOF;
            endcase
         end else begin
            if (gap != TIMEOUT) gap <= gap + 16'd1;
            if (rx_state != RX_SOF && gap == TIMEOUT - 16'd1) rx_state <= RX_SOF;
         end
      end
   end

   tx_state_t      tx_state;
   logic [AW-1:0]  ch;
   logic [AW-1:0]  last;
   logic [7:0]     tcnt;
   logic [N_CH-1:0] req;
   logic [N_CH-1:0] grant;
   logic [AW-1:0]  gnt_idx;
   logic           gnt_hit;
   logic [7:0]     len_sel;
   logic [7:0]     head;
   logic           load;

   always_comb begin
      req     = '0;
      len_sel = '0;
      for (int k = 0; k < N_CH; k++) begin
         req[k] = have_msg_bus[k] && (len_bus[8*k +: 8] != 8'd0);
         if (grant[k]) len_sel = len_sel | len_bus[8*k +: 8];
      end
   end

   rr_arbiter #(.N(N_CH), .IW(AW)) u_arb (
      .req   (req),
      .last  (last),
      .grant (grant),
      .idx   (gnt_idx),
      .hit   (gnt_hit)
   );

   assign load = !tx_valid || tx_ready;
   assign head = slave_data_bus[{ch, 3'b000} +: 8];

   // The pop must coincide with the load edge so a show-ahead FIFO presents the
   // next head in time for back-to-back payload bytes.
   assign rdreq_bus = (tx_state == TX_PAY && load) ? (N_CH'(1) << ch) : '0;

   always_ff @(posedge sys_clk or negedge n_rst) begin
      if (!n_rst) begin
         tx_state <= TX_SCAN;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         ch       <= '0;
         last     <= AW'(N_CH - 1);
         tcnt     <= '0;
      end else begin
         if (load) tx_valid <= 1'b0;
         case (tx_state)
            TX_SCAN: begin
               if (gnt_hit) begin
                  ch       <= gnt_idx;
                  last     <= gnt_idx;
                  tcnt     <= len_sel;
                  tx_state <= TX_SOF;
               end
            end
            TX_SOF: begin
               if (load) begin
                  tx_data  <= SOF_TX;
                  tx_valid <= 1'b1;
                  tx_state <= TX_ADDR;
               end
            end
            TX_ADDR: begin
               if (load) begin
                  tx_data  <= 8'(ch);
                  tx_valid <= 1'b1;
                  tx_state <= TX_LEN;
               end
            end
            TX_LEN: begin
               if (load) begin
                  tx_data  <= tcnt;
                  tx_valid <= 1'b1;
                  tx_state <= TX_PAY;
               end
            end
            TX_PAY: begin
               if (load) begin
                  tx_data  <= head;
                  tx_valid <= 1'b1;
                  tcnt     <= tcnt - 8'd1;
                  if (tcnt == 8'd1) tx_state <= TX_SCAN;
               end
            end
            default: tx_state <= TX_SCAN;
         endcase
      end
   end

endmodule

// File: doc/host_bus_master.md
# host_bus_master

Full-duplex bridge between the host byte link and the internal per-channel message bus consumed by the functional-test and configuration blocks. Downstream, it parses host command packets and replays their payloads as `master_data` bytes qualified by one-hot `valid_bus` strobes. Upstream, it scans `have_msg_bus` round-robin, then drains the selected channel through `rdreq_bus`/`slave_data_bus` into framed reply packets toward the host. It is the initiator side of the `valid_bus`/`rdreq_bus`/`have_msg_bus`/`len_bus` interface.

## Interface
- `N_CH`, 5: number of bus channels (addresses 0..N_CH-1).
- `TIMEOUT`, 16'd50000: max idle cycles between bytes of one rx packet before abort.
- `SOF_RX`, 8'hAA: host-to-FPGA start byte.
- `SOF_TX`, 8'h55: FPGA-to-host start byte.

Ports (one clock: `sys_clk`; reset `n_rst` is asynchronous, active-low):
- `sys_clk` in 1: system clock, all logic rising-edge.
- `n_rst` in 1: async active-low reset.
- `rx_data` in 8: host byte.
- `rx_valid` in 1: one-cycle strobe per host byte; there is no backpressure.
- `tx_data` out 8: reply byte.
- `tx_valid` out 1: reply byte present; held until accepted.
- `tx_ready` in 1: host link accepts `tx_data` when `tx_valid & tx_ready`.
- `master_data` out 8: payload byte to channels.
- `valid_bus` out N_CH: one-hot strobe qualifying `master_data`.
- `have_msg_bus` in N_CH: channel k has data to send.
- `len_bus` in 8*N_CH: channel k byte count at `[8k+7:8k]`, saturated at 255 by the channel.
- `rdreq_bus` out N_CH: one-cycle pop to channel k FIFO.
- `slave_data_bus` in 8*N_CH: show-ahead head byte of channel k at `[8k+7:8k]`.

## Operation
**Rx FSM** (states RX_SOF, RX_ADDR, RX_LEN, RX_PAY):
- RX_SOF: discard any byte ≠ SOF_RX. On SOF_RX, go to RX_ADDR.
- RX_ADDR: latch `addr` and go to RX_LEN.
- RX_LEN: latch `cnt`. If `cnt`=0, return to RX_SOF; otherwise go to RX_PAY.
- RX_PAY: each rx byte is registered to `master_data`, and `valid_bus[addr]` is pulsed. Then `cnt` decrements; at 0, return to RX_SOF.
- `addr` ≥ N_CH: the payload is consumed and counted, but no `valid_bus` bit is ever asserted.
- Timeout: a gap counter resets on every `rx_valid`. If it reaches TIMEOUT in any state other than RX_SOF, the FSM returns to RX_SOF. Bytes already forwarded stand.

**Tx FSM** (states TX_SCAN, TX_SOF, TX_ADDR, TX_LEN, TX_PAY):
- TX_SCAN: search from `last+1` (mod N_CH) for the first k with `have_msg_bus[k]=1` and `len≠0`. Latch `ch=k`, `last=k`, and `tcnt=len_bus[k]`, then go to TX_SOF. No hit: stay.
- TX_SOF, TX_ADDR, TX_LEN load `tx_data` with SOF_TX, `ch`, and `tcnt` respectively.
- TX_PAY: each load takes `slave_data_bus[ch]` into `tx_data` and pulses `rdreq_bus[ch]` in the same cycle. `tcnt` decrements; at 0, return to TX_SCAN.
- Load rule: the tx holding register is loaded only when `!tx_valid | tx_ready`. The FSM advances only on a load.
- The latched length is authoritative. Exactly `tcnt` bytes are sent even if `have_msg_bus` drops or `len_bus` grows meanwhile.

Rx and tx are independent and may be active in the same cycle.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `master_data`=0, `valid_bus`=0, `rdreq_bus`=0. Both FSMs reset to their scan/SOF state, `last`=N_CH-1, and all counters are 0.
- Rx latency: `valid_bus` and `master_data` rise exactly 1 cycle after the `rx_valid` of a payload byte. Each strobe is one cycle wide, at most one strobe per cycle.
- Tx latency: `tx_valid` with SOF_TX appears 2 cycles after `have_msg_bus[k]` rises in TX_SCAN: 1 cycle to scan and latch, 1 cycle to load.
- With `tx_ready` held at 1, there is one byte per cycle, and the `rdreq` pulses are back-to-back.
- `rdreq_bus` is never asserted outside TX_PAY and never more than once per accepted load.
- Reset mid-packet aborts both directions immediately. Outputs drop to their reset values asynchronously.

## Structure
- A shared package holds `SOF_RX`, `SOF_TX`, and the rx/tx state localparams, so that channel blocks and host-side software definitions share one source.
- Sub-module `rr_arbiter` (N_CH requests, `last` pointer in, one-hot grant plus index out, combinational) is used by TX_SCAN.

## Test plan
- Rx: AA 03 02 12 34 → `valid_bus`=5'b01000 pulses twice, `master_data` 12 then 34. No other strobes.
- Rx garbage/zero length/bad address: bytes 00 AA 02 00 AA 07 01 FF → no strobes at all. The next packet AA 01 01 5C → `valid_bus[1]` pulses with 5C.
- Rx timeout: AA 04 03 11, then a gap of TIMEOUT cycles, then AA 00 01 77 → one strobe with 11 on ch4, then `valid_bus[0]` with 77.
- Tx: `have_msg_bus[4]`=1, `len`=3, FIFO D0 D1 D2, `tx_ready`=1 → `tx_data` 55 04 03 D0 D1 D2 on consecutive cycles, and `rdreq_bus[4]` pulses 3 times.
- Round robin: ch2 and ch4 pending, `last`=2 → ch4 is served fully first, then ch2. Length 0 on a pending channel → that channel is skipped.
- Backpressure: `tx_ready` toggles 1-0-0-1 during the payload → `tx_data` is stable while `tx_valid & !tx_ready`, and the `rdreq` count equals the number of payload bytes accepted.
